input_conditioner: RTL

Parametrised front end for all board-level user inputs: column-select switches and push-buttons. Raw pad signals from the DE-series board go in; clean, synchronous, debounced levels and single-cycle press/release pulses come out to the game controller. Every input gets a two-flop synchroniser and a counter-based debounce filter. Button polarity is selectable, and the switch bus is filtered as a group so that no transient column code ever reaches the game logic.

---
 rtl/input_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 73 +++++++
 rtl/input_conditioner.sv | 65 ++++++
 3 files changed

// File: rtl/input_pkg.sv
// Shared constants for the board input front end.
//   SW_WIDTH_DEF / NUM_KEYS_DEF / DEBOUNCE_50MHZ_10MS : default build sizes
//   KEY_CONFIRM1 / KEY_CONFIRM2 / KEY_RESET           : key channel indices
//   cnt_width()                                       : debounce counter width helper
package input_pkg;

    localparam int unsigned SW_WIDTH_DEF        = 3;
    localparam int unsigned NUM_KEYS_DEF        = 3;
    localparam int unsigned DEBOUNCE_50MHZ_10MS = 500000;

    localparam int unsigned KEY_CONFIRM1 = 0;
    localparam int unsigned KEY_CONFIRM2 = 1;
    localparam int unsigned KEY_RESET    = 2;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Two-flop synchroniser followed by a counter debounce filter on a WIDTH-bit group.
//   clk, reset : clock and synchronous active-high reset
//   din        : raw asynchronous input (already normalised to active-high)
//   level      : debounced value (registered)
//   changed    : one-cycle pulse in the cycle level takes a new value (registered)
module debounce_channel
    import input_pkg::*;
#(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic             changed
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_eff;
    logic             changed_q, changed_d;

    // Next-state: a freshly arrived synchronised value always counts from zero,
    // so a group that hops between non-stable codes restarts its qualification.
    always_comb begin
        s1_d      = din;
        s2_d      = s1_q;
        last_d    = s2_q;
        stable_d  = stable_q;
        cnt_d     = '0;
        changed_d = 1'b0;
        cnt_eff   = (s2_q != last_q) ? '0 : cnt_q;

        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_eff == CNT_LAST) begin
            stable_d  = s2_q;
            changed_d = 1'b1;
        end else begin
            cnt_d = cnt_eff + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            last_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            last_q    <= last_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end

    assign level   = stable_q;
    assign changed = changed_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: synchronises and debounces switches and push-buttons.
//   clk, reset     : clock and synchronous active-high reset
//   switches       : raw switch bus, filtered as one group
//   keys           : raw buttons, polarity chosen by KEY_ACTIVE_LOW
//   column         : debounced switch value
//   column_changed : pulse when column takes a new value
//   key_level      : debounced active-high pressed level per key
//   key_press      : pulse on key_level 0->1
//   key_release    : pulse on key_level 1->0
module input_conditioner
    import input_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = SW_WIDTH_DEF,
    parameter int unsigned NUM_KEYS        = NUM_KEYS_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [SW_WIDTH-1:0] column,
    output logic                column_changed,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    logic [NUM_KEYS-1:0] key_norm;
    logic [NUM_KEYS-1:0] key_chg;

    // Everything downstream sees keys as active-high.
    assign key_norm = KEY_ACTIVE_LOW ? ~keys : keys;

    // One independent filter per key.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        debounce_channel #(
            .WIDTH           (1),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key (
            .clk     (clk),
            .reset   (reset),
            .din     (key_norm[k]),
            .level   (key_level[k]),
            .changed (key_chg[k])
        );
    end

    // Switch bus filtered as a whole so no intermediate column code escapes.
    debounce_channel #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw (
        .clk     (clk),
        .reset   (reset),
        .din     (switches),
        .level   (column),
        .changed (column_changed)
    );

    // Change pulse and new level are both flop outputs; direction picks the pulse.
    assign key_press   = key_chg &  key_level;
    assign key_release = key_chg & ~key_level;

endmodule
